pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage processor. Each cycle it drives the write enables and bubble/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It detects load-use hazards, squashes wrong-path instructions on taken branches, freezes the pipe during data-memory waits, and enters a sticky halt. It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core.
// Generates the PC and pipeline register enables and the bubble/flush controls.
// Detects load-use hazards, defers branch flushes across memory waits and
// holds the pipe in a sticky halt. Keeps saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic                  id_rs_used,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_rt_used,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  br_taken,
  input  logic                  mem_busy,
  input  logic                  wb_halt,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_HALTED  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_br_pend;
  logic             w_br_pend_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lu;
  logic             w_flush_evt;
  logic             w_stall_evt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_lu = ex_mem_read &
                ((id_rs_used & (id_rs_addr == ex_rd_addr)) |
                 (id_rt_used & (id_rt_addr == ex_rd_addr)));

  // Next-state and enable/flush decode. MEMWAIT with memory ready is
  // evaluated with the RUN rules, so both states share one decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_br_pend_nxt = r_br_pend;
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    w_flush_evt   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN, ST_MEMWAIT: begin
          if (mem_busy) begin
            // Freeze everything; a branch resolved now must flush later.
            if (br_taken) w_br_pend_nxt = 1'b1;
            w_state_nxt = ST_MEMWAIT;
          end else if (wb_halt) begin
            w_state_nxt = ST_HALTED;
          end else if (br_taken | r_br_pend) begin
            // Squash the two wrong-path instructions in IF/ID and ID/EX.
            pc_en         = 1'b1;
            ifid_en       = 1'b1;
            idex_en       = 1'b1;
            exmem_en      = 1'b1;
            memwb_en      = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            w_br_pend_nxt = 1'b0;
            w_flush_evt   = 1'b1;
            w_state_nxt   = ST_RUN;
          end else if (w_lu) begin
            // Hold PC and IF/ID, push one bubble into EX.
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_HALTED: w_state_nxt = ST_HALTED;
        default:   w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign w_stall_evt = ~rst & ~pc_en & (r_state != ST_HALTED);

  // State, pending-branch flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_br_pend   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_br_pend <= w_br_pend_nxt;
      if (w_stall_evt) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush_evt) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign halted    = (r_state == ST_HALTED);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a scoreboard queue.
module tb_pipe_hazard_ctrl;

  localparam int RW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs_addr, id_rt_addr, ex_rd_addr;
  logic          id_rs_used, id_rt_used, ex_mem_read;
  logic          br_taken, mem_busy, wb_halt;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .br_taken(br_taken), .mem_busy(mem_busy), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [6:0]    ctl;
    logic          h;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_total = 0;
  int   n_pass  = 0;

  localparam logic [6:0] RUNV = 7'b1111100;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] LUS  = 7'b0011101;
  localparam logic [6:0] FLS  = 7'b1111111;

  // Pop one expectation per cycle and compare mid-cycle.
  always @(negedge clk) begin
    logic [6:0] obs;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
      n_total++;
      assert (obs === e.ctl) n_pass++;
      else $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
      n_total++;
      assert (halted === e.h) n_pass++;
      else $error("FAIL %s halted observed=%b expected=%b", e.tag, halted, e.h);
      n_total++;
      assert ({stall_cnt, flush_cnt} === {e.sc, e.fc}) n_pass++;
      else $error("FAIL %s counters observed=%0d/%0d expected=%0d/%0d",
                  e.tag, stall_cnt, flush_cnt, e.sc, e.fc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs_addr = '0; id_rs_used = 1'b0;
    id_rt_addr = '0; id_rt_used = 1'b0;
    ex_mem_read = 1'b0; ex_rd_addr = '0;
    br_taken = 1'b0; mem_busy = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic lu_rs();
    ex_mem_read = 1'b1; ex_rd_addr = 3'd3;
    id_rs_used = 1'b1; id_rs_addr = 3'd3;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] ctl,
                            input logic h, input int sc, input int fc);
    exp_t x;
    x.tag = tag;
    x.ctl = ctl;
    x.h   = h;
    x.sc  = sc[CW-1:0];
    x.fc  = fc[CW-1:0];
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset state
    cyc(); expect_out("reset", FRZ, 0, 0, 0);
    cyc(); rst = 1'b0; expect_out("idle", RUNV, 0, 0, 0);
    // Load-use on rs
    cyc(); lu_rs(); expect_out("lu_rs", LUS, 0, 0, 0);
    cyc(); idle(); expect_out("lu_after", RUNV, 0, 1, 0);
    // Load-use on rt
    cyc(); ex_mem_read = 1'b1; ex_rd_addr = 3'd5; id_rs_used = 1'b1; id_rs_addr = 3'd3;
    id_rt_used = 1'b1; id_rt_addr = 3'd5; expect_out("lu_rt", LUS, 0, 1, 0);
    cyc(); id_rt_used = 1'b0; expect_out("rt_unused", RUNV, 0, 2, 0);
    cyc(); id_rt_used = 1'b1; ex_mem_read = 1'b0; expect_out("not_load", RUNV, 0, 2, 0);
    // Branch together with load-use
    cyc(); ex_mem_read = 1'b1; br_taken = 1'b1; expect_out("br_lu", FLS, 0, 2, 0);
    cyc(); idle(); expect_out("br_after", RUNV, 0, 2, 1);
    // Deferred branch across a 3-cycle memory wait
    cyc(); mem_busy = 1'b1; expect_out("mw1", FRZ, 0, 2, 1);
    cyc(); br_taken = 1'b1; expect_out("mw2_br", FRZ, 0, 3, 1);
    cyc(); br_taken = 1'b0; expect_out("mw3", FRZ, 0, 4, 1);
    cyc(); mem_busy = 1'b0; expect_out("pend_flush", FLS, 0, 5, 1);
    cyc(); expect_out("pend_done", RUNV, 0, 5, 2);
    // Reset mid-MEMWAIT with a pending branch
    cyc(); mem_busy = 1'b1; br_taken = 1'b1; expect_out("mw_pend", FRZ, 0, 5, 2);
    cyc(); rst = 1'b1; br_taken = 1'b0; expect_out("rst_mw", FRZ, 0, 6, 2);
    cyc(); rst = 1'b0; mem_busy = 1'b0; expect_out("rst_no_flush", RUNV, 0, 0, 0);
    cyc(); expect_out("rst_idle", RUNV, 0, 0, 0);
    // Halt arriving during a memory wait
    cyc(); mem_busy = 1'b1; wb_halt = 1'b1; expect_out("busy_halt", FRZ, 0, 0, 0);
    cyc(); mem_busy = 1'b0; expect_out("halt_take", FRZ, 0, 1, 0);
    cyc(); wb_halt = 1'b0; br_taken = 1'b1; mem_busy = 1'b1; expect_out("halted1", FRZ, 1, 2, 0);
    cyc(); mem_busy = 1'b0; lu_rs(); expect_out("halted2", FRZ, 1, 2, 0);
    cyc(); idle(); rst = 1'b1; expect_out("halt_rst", FRZ, 1, 2, 0);
    cyc(); rst = 1'b0; expect_out("halt_cleared", RUNV, 0, 0, 0);
    // Halt taken directly in RUN
    cyc(); wb_halt = 1'b1; expect_out("run_halt", FRZ, 0, 0, 0);
    cyc(); wb_halt = 1'b0; br_taken = 1'b1; expect_out("run_halted", FRZ, 1, 1, 0);
    cyc(); idle(); rst = 1'b1; expect_out("run_halt_rst", FRZ, 1, 1, 0);
    cyc(); rst = 1'b0; expect_out("run_cleared", RUNV, 0, 0, 0);
    // Stall counter saturation
    for (int k = 0; k < 20; k++) begin
      cyc(); lu_rs(); expect_out("sat", LUS, 0, (k > 15) ? 15 : k, 0);
    end
    cyc(); idle(); expect_out("sat_hold", RUNV, 0, 15, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
